// File: rtl/mux_rr_reg.sv
// Registered N-channel selector: fixed-select or round-robin over valid channels,
// combinational one-hot grant and a one-cycle registered output word.
module mux_rr_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [CHANNELS-1:0]       grant,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SEL_W-1:0]          chan_out,
    output logic                      sel_err
);

    generate
        if (CHANNELS < 2 || CHANNELS > 16 || CHANNELS > (1 << SEL_W)) begin : g_bad_params
            $error("mux_rr_reg: CHANNELS must be 2..16 and fit in SEL_W bits");
        end
    endgenerate

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic [SEL_W-1:0] chan_out_q, chan_out_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             sample;
    logic             sel_in_range;
    logic             hit;
    int               pick;
    int               idx;
    int               nxt;
    logic [WIDTH-1:0] word;

    assign sample       = enable && !reset;
    assign sel_in_range = int'(sel) < CHANNELS;

    // Channel selection: pick is only meaningful while hit is set.
    always_comb begin
        hit  = 1'b0;
        pick = 0;
        idx  = 0;
        if (sample) begin
            if (!mode) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (sel_in_range && int'(sel) == k && valid_in[k]) begin
                        hit  = 1'b1;
                        pick = k;
                    end
                end
            end else begin
                // Search order ptr, ptr+1, ..., wrapping at CHANNELS rather than 2**SEL_W.
                for (int off = 0; off < CHANNELS; off++) begin
                    idx = int'(ptr_q) + off;
                    if (idx >= CHANNELS) begin
                        idx = idx - CHANNELS;
                    end
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (!hit && k == idx && valid_in[k]) begin
                            hit  = 1'b1;
                            pick = k;
                        end
                    end
                end
            end
        end
    end

    // Only the granted channel's slice is routed, so X on idle channels cannot leak.
    always_comb begin
        grant = '0;
        word  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (hit && pick == k) begin
                grant[k] = 1'b1;
                word     = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        nxt = (pick + 1 >= CHANNELS) ? 0 : pick + 1;

        valid_out_d = hit;
        data_out_d  = hit ? word : data_out_q;
        chan_out_d  = hit ? SEL_W'(pick) : chan_out_q;
        ptr_d       = (hit && mode) ? SEL_W'(nxt) : ptr_q;
        sel_err_d   = sel_err_q || (sample && !mode && !sel_in_range);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            chan_out_q  <= '0;
            sel_err_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            chan_out_q  <= chan_out_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign chan_out  = chan_out_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: a 4-channel instance and a 3-channel instance
// exercising fixed mode, round-robin fairness, wrap, idle/enable, errors and reset.
module tb_mux_rr_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-channel instance
    logic        rst4;
    logic [31:0] d4;
    logic [3:0]  v4;
    logic        en4, mode4;
    logic [1:0]  sel4;
    logic [3:0]  g4;
    logic [7:0]  do4;
    logic        vo4;
    logic [1:0]  co4;
    logic        se4;

    // 3-channel instance
    logic        rst3;
    logic [23:0] d3;
    logic [2:0]  v3;
    logic        en3, mode3;
    logic [1:0]  sel3;
    logic [2:0]  g3;
    logic [7:0]  do3;
    logic        vo3;
    logic [1:0]  co3;
    logic        se3;

    mux_rr_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u4 (
        .clk(clk), .reset(rst4), .data_in(d4), .valid_in(v4), .enable(en4),
        .mode(mode4), .sel(sel4), .grant(g4), .data_out(do4), .valid_out(vo4),
        .chan_out(co4), .sel_err(se4)
    );

    mux_rr_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u3 (
        .clk(clk), .reset(rst3), .data_in(d3), .valid_in(v3), .enable(en3),
        .mode(mode3), .sel(sel3), .grant(g3), .data_out(do3), .valid_out(vo3),
        .chan_out(co3), .sel_err(se3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst3 = 1'b1;
        d4 = 32'hD3C2B1A0; v4 = 4'b1111; en4 = 1'b1; mode4 = 1'b1; sel4 = 2'd0;
        d3 = 24'h332211;   v3 = 3'b111;  en3 = 1'b1; mode3 = 1'b1; sel3 = 2'd0;
        #1;
        checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL reset_grant4: got %b expected 0000", g4); end
        checks++; if (g3 !== 3'b000) begin errors++; $display("FAIL reset_grant3: got %b expected 000", g3); end
        tick();
        tick();
        checks++; if (do4 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", do4); end
        checks++; if (vo4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vo4); end
        checks++; if (co4 !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", co4); end
        checks++; if (se4 !== 1'b0) begin errors++; $display("FAIL reset_selerr: got %b expected 0", se4); end
        checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL reset_grant_hold: got %b expected 0000", g4); end
        checks++; if (vo3 !== 1'b0 || se3 !== 1'b0) begin errors++; $display("FAIL reset3_outs: got vo=%b se=%b expected 0 0", vo3, se3); end
        en3 = 1'b0; v3 = 3'b000;
        rst4 = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_fixed();
        d4 = 32'hD3C2B1A0; v4 = 4'b1111; en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd2;
        #1;
        checks++; if (g4 !== 4'b0100) begin errors++; $display("FAIL fixed_grant: got %b expected 0100", g4); end
        tick();
        checks++; if (do4 !== 8'hC2) begin errors++; $display("FAIL fixed_data: got %h expected c2", do4); end
        checks++; if (co4 !== 2'd2) begin errors++; $display("FAIL fixed_chan: got %0d expected 2", co4); end
        checks++; if (vo4 !== 1'b1) begin errors++; $display("FAIL fixed_valid: got %b expected 1", vo4); end
        v4 = 4'b1011;
        #1;
        checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL fixed_invalid_grant: got %b expected 0000", g4); end
        tick();
        checks++; if (vo4 !== 1'b0) begin errors++; $display("FAIL fixed_invalid_valid: got %b expected 0", vo4); end
        checks++; if (do4 !== 8'hC2) begin errors++; $display("FAIL fixed_hold_data: got %h expected c2", do4); end
        checks++; if (co4 !== 2'd2) begin errors++; $display("FAIL fixed_hold_chan: got %0d expected 2", co4); end
    endtask

    task automatic test_rr_fairness();
        int exp_ch [6] = '{0, 1, 3, 0, 1, 3};
        logic [7:0] exp_d [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        logic [3:0] exp_g;
        mode4 = 1'b1; v4 = 4'b1011; en4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_g = 4'b0001 << exp_ch[i];
            #1;
            checks++; if (g4 !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, g4, exp_g); end
            tick();
            checks++; if (co4 !== 2'(exp_ch[i]) || vo4 !== 1'b1 || do4 !== exp_d[exp_ch[i]])
                begin errors++; $display("FAIL rr_out[%0d]: got ch=%0d v=%b d=%h expected ch=%0d v=1 d=%h", i, co4, vo4, do4, exp_ch[i], exp_d[exp_ch[i]]); end
        end
    endtask

    task automatic test_idle_enable();
        mode4 = 1'b1; en4 = 1'b1; v4 = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL idle_grant[%0d]: got %b expected 0000", i, g4); end
            tick();
            checks++; if (vo4 !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b expected 0", i, vo4); end
        end
        v4 = 4'b0100;
        tick();
        checks++; if (co4 !== 2'd2 || vo4 !== 1'b1) begin errors++; $display("FAIL idle_then_ch2: got ch=%0d v=%b expected ch=2 v=1", co4, vo4); end
        // ptr is now 3; disabled cycles must not move it
        en4 = 1'b0; v4 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL disabled_grant[%0d]: got %b expected 0000", i, g4); end
            tick();
            checks++; if (vo4 !== 1'b0 || co4 !== 2'd2) begin errors++; $display("FAIL disabled_out[%0d]: got v=%b ch=%0d expected v=0 ch=2", i, vo4, co4); end
        end
        en4 = 1'b1;
        #1;
        checks++; if (g4 !== 4'b1000) begin errors++; $display("FAIL enable_resume_grant: got %b expected 1000", g4); end
        tick();
        checks++; if (co4 !== 2'd3 || do4 !== 8'hD3) begin errors++; $display("FAIL enable_resume_out: got ch=%0d d=%h expected ch=3 d=d3", co4, do4); end
    endtask

    task automatic test_xprop();
        mode4 = 1'b0; sel4 = 2'd1; v4 = 4'b0010; en4 = 1'b1;
        d4 = {8'hxx, 8'hzz, 8'hB1, 8'hxx};
        #1;
        checks++; if (g4 !== 4'b0010) begin errors++; $display("FAIL xprop_grant: got %b expected 0010", g4); end
        tick();
        checks++; if (do4 !== 8'hB1 || co4 !== 2'd1) begin errors++; $display("FAIL xprop_data: got d=%h ch=%0d expected d=b1 ch=1", do4, co4); end
        en4 = 1'b0; d4 = 32'hD3C2B1A0;
    endtask

    task automatic test_rr3_wrap();
        int exp_ch [4] = '{0, 1, 2, 0};
        mode3 = 1'b1; v3 = 3'b111; en3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (co3 !== 2'(exp_ch[i]) || vo3 !== 1'b1) begin errors++; $display("FAIL rr3_chan[%0d]: got ch=%0d v=%b expected ch=%0d v=1", i, co3, vo3, exp_ch[i]); end
        end
    endtask

    task automatic test_err_reset();
        mode3 = 1'b0; sel3 = 2'd3; v3 = 3'b111; en3 = 1'b1;
        #1;
        checks++; if (g3 !== 3'b000) begin errors++; $display("FAIL err_grant: got %b expected 000", g3); end
        tick();
        checks++; if (vo3 !== 1'b0 || se3 !== 1'b1) begin errors++; $display("FAIL err_flag: got v=%b se=%b expected v=0 se=1", vo3, se3); end
        sel3 = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (se3 !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d]: got %b expected 1", i, se3); end
        end
        // ptr is 1 after the wrap test; one round-robin sample moves it to 2
        mode3 = 1'b1;
        tick();
        checks++; if (co3 !== 2'd1 || do3 !== 8'h22) begin errors++; $display("FAIL burst_chan: got ch=%0d d=%h expected ch=1 d=22", co3, do3); end
        rst3 = 1'b1;
        #1;
        checks++; if (g3 !== 3'b000) begin errors++; $display("FAIL midreset_grant: got %b expected 000", g3); end
        tick();
        rst3 = 1'b0;
        checks++; if (se3 !== 1'b0 || vo3 !== 1'b0 || co3 !== 2'd0 || do3 !== 8'h00)
            begin errors++; $display("FAIL midreset_outs: got se=%b v=%b ch=%0d d=%h expected 0 0 0 00", se3, vo3, co3, do3); end
        v3 = 3'b110;
        #1;
        checks++; if (g3 !== 3'b010) begin errors++; $display("FAIL post_reset_grant: got %b expected 010", g3); end
        tick();
        checks++; if (co3 !== 2'd1 || vo3 !== 1'b1) begin errors++; $display("FAIL post_reset_chan: got ch=%0d v=%b expected ch=1 v=1", co3, vo3); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_fairness();
        test_idle_enable();
        test_xprop();
        test_rr3_wrap();
        test_err_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
